// File: rtl/service_window_initiator_if.sv
// Service-window initiator bundle: supervisor request/response plus responder link.
interface service_window_initiator_if #(
    parameter int unsigned LEN_W = 16
);
    logic             REQ;
    logic [LEN_W-1:0] LEN;
    logic             SWSTAT;
    logic             INIT;
    logic [LEN_W-1:0] SWLEN;
    logic             BUSY;
    logic             ACK;
    logic             ERR;
    logic [1:0]       ERRCODE;
    logic [LEN_W-1:0] ELAPSED;

    // Initiator view: consumes the request and responder status, drives everything else.
    modport master (
        input  REQ, LEN, SWSTAT,
        output INIT, SWLEN, BUSY, ACK, ERR, ERRCODE, ELAPSED
    );

    // Environment view: supervisor plus responder.
    modport slave (
        output REQ, LEN, SWSTAT,
        input  INIT, SWLEN, BUSY, ACK, ERR, ERRCODE, ELAPSED
    );
endinterface

// File: rtl/service_window_initiator.sv
// Initiator side of the service-window link: pulses INIT, then times the window reported
// on SWSTAT and reports ACK or a coded ERR. All outputs come straight from flops.
module service_window_initiator #(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned INIT_PULSE = 2,
    parameter int unsigned OPEN_TO    = 4,
    parameter int unsigned GUARD      = 4
) (
    input logic                        CLK,
    input logic                        RST,
    service_window_initiator_if.master sw
);
    localparam int unsigned CW = LEN_W + 1;

    localparam logic [CW-1:0] PULSE_C = CW'(INIT_PULSE);
    localparam logic [CW-1:0] OPEN_C  = CW'(OPEN_TO);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    localparam logic [1:0] CodeNoOpen  = 2'b01;
    localparam logic [1:0] CodeEarly   = 2'b10;
    localparam logic [1:0] CodeTimeout = 2'b11;

    typedef enum logic [1:0] {StIdle, StPulse, StOpenWait, StActive} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             init_q, init_d;
    logic [LEN_W-1:0] swlen_q, swlen_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [1:0]       errcode_q, errcode_d;
    logic [LEN_W-1:0] elapsed_q, elapsed_d;

    logic [CW-1:0] limit_hi;
    logic [CW-1:0] limit_lo;
    logic [CW-1:0] cnt_inc;

    // Clamp a one-bit-wider count to the reported width.
    function automatic logic [LEN_W-1:0] sat(input logic [CW-1:0] v);
        return v[CW-1] ? {LEN_W{1'b1}} : v[LEN_W-1:0];
    endfunction

    // Window tolerance bounds, one bit wider than SWLEN so neither wraps.
    always_comb begin
        limit_hi = {1'b0, swlen_q} + GUARD_C;
        limit_lo = ({1'b0, swlen_q} >= GUARD_C) ? ({1'b0, swlen_q} - GUARD_C) : '0;
        cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_d    = init_q;
        swlen_d   = swlen_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        errcode_d = errcode_q;
        elapsed_d = elapsed_q;

        unique case (state_q)
            StIdle: begin
                if (sw.REQ) begin
                    swlen_d   = sw.LEN;
                    errcode_d = 2'b00;
                    elapsed_d = '0;
                    busy_d    = 1'b1;
                    init_d    = 1'b0;
                    cnt_d     = CW'(1);
                    state_d   = StPulse;
                end
            end

            StPulse: begin
                if (cnt_q >= PULSE_C) begin
                    init_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StOpenWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StOpenWait: begin
                if (!sw.SWSTAT) begin
                    cnt_d   = '0;
                    state_d = StActive;
                end else if (cnt_q + 1'b1 >= OPEN_C) begin
                    err_d     = 1'b1;
                    errcode_d = CodeNoOpen;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StActive: begin
                // Close needs SWSTAT=1 and timeout needs SWSTAT=0, so close always wins.
                if (sw.SWSTAT) begin
                    elapsed_d = sat(cnt_q);
                    if (cnt_q < limit_lo) begin
                        err_d     = 1'b1;
                        errcode_d = CodeEarly;
                    end else begin
                        ack_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= limit_hi) begin
                        elapsed_d = sat(cnt_inc);
                        err_d     = 1'b1;
                        errcode_d = CodeTimeout;
                        busy_d    = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State register; reset parks INIT high so it never pulses low on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            init_q    <= 1'b1;
            swlen_q   <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= 2'b00;
            elapsed_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            swlen_q   <= swlen_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
            elapsed_q <= elapsed_d;
        end
    end

    assign sw.INIT    = init_q;
    assign sw.SWLEN   = swlen_q;
    assign sw.BUSY    = busy_q;
    assign sw.ACK     = ack_q;
    assign sw.ERR     = err_q;
    assign sw.ERRCODE = errcode_q;
    assign sw.ELAPSED = elapsed_q;
endmodule

// File: tb/tb_service_window_initiator.sv
// Bench for service_window_initiator: behavioural responder plus expected-result queue.
module tb_service_window_initiator;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned INIT_PULSE = 2;
    localparam int unsigned OPEN_TO    = 4;
    localparam int unsigned GUARD      = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    service_window_initiator_if #(.LEN_W(LEN_W)) sw ();

    service_window_initiator #(
        .LEN_W(LEN_W),
        .INIT_PULSE(INIT_PULSE),
        .OPEN_TO(OPEN_TO),
        .GUARD(GUARD)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .sw(sw.master)
    );

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [1:0]  code;
        logic [15:0] elapsed;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    // Responder: 0 = conforming (low from INIT fall until close_n ACTIVE samples after INIT
    // rises), 1 = SWSTAT stuck high, 2 = SWSTAT stuck low.
    int          mode = 1;
    int unsigned close_n = 0;
    int unsigned down;

    always @(posedge clk or posedge rst) begin
        if (rst) down <= 0;
        else if (sw.INIT === 1'b0) down <= close_n + 1;
        else if (down != 0) down <= down - 1;
    end

    assign sw.SWSTAT = (mode == 1) ? 1'b1 :
                       (mode == 2) ? 1'b0 :
                       !((sw.INIT === 1'b0) || (down != 0));

    int init_falls = 0;
    int done_pulses = 0;
    always @(negedge sw.INIT) init_falls++;
    always @(posedge clk) if (sw.ACK === 1'b1 || sw.ERR === 1'b1) done_pulses++;

    // Independent outcome model for one window.
    function automatic res_t predict(input int m, input logic [15:0] len, input int unsigned n);
        int unsigned hi;
        int unsigned lo;
        res_t r;
        hi = int'(len) + GUARD;
        lo = (int'(len) >= GUARD) ? int'(len) - GUARD : 0;
        r = '0;
        if (m == 1) begin
            r.err = 1'b1; r.code = 2'b01; r.elapsed = 16'd0;
        end else if (m == 2 || n >= hi) begin
            r.err = 1'b1; r.code = 2'b11;
            r.elapsed = (hi > 65535) ? 16'hFFFF : 16'(hi);
        end else if (n < lo) begin
            r.err = 1'b1; r.code = 2'b10; r.elapsed = 16'(n);
        end else begin
            r.ack = 1'b1; r.elapsed = 16'(n);
        end
        return r;
    endfunction

    // Drive one accepted request; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] len);
        sw.REQ = 1'b1;
        sw.LEN = len;
        @(negedge clk);
        sw.REQ = 1'b0;
    endtask

    // Sample each negedge until ACK/ERR or the budget runs out.
    task automatic wait_done(input int budget, output bit to, output res_t obs,
                             output int low_cnt, output int rise_gap);
        int idx;
        int rise_idx;
        bit seen_low;
        idx = 0; rise_idx = -1; seen_low = 0;
        to = 0; obs = '0; low_cnt = 0; rise_gap = -1;
        forever begin
            if (sw.INIT === 1'b0) begin
                low_cnt++;
                seen_low = 1;
            end else if (seen_low && rise_idx < 0) begin
                rise_idx = idx;
            end
            if (sw.ACK === 1'b1 || sw.ERR === 1'b1) begin
                obs = {sw.ACK, sw.ERR, sw.ERRCODE, sw.ELAPSED};
                if (rise_idx >= 0) rise_gap = idx - rise_idx;
                return;
            end
            if (idx >= budget) begin
                to = 1;
                return;
            end
            @(negedge clk);
            idx++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({sw.INIT, sw.BUSY, sw.ACK, sw.ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got INIT/BUSY/ACK/ERR=%b want 1000",
                     {sw.INIT, sw.BUSY, sw.ACK, sw.ERR});
        end
        checks++;
        if ({sw.SWLEN, sw.ERRCODE, sw.ELAPSED} !== 34'd0) begin
            errors++;
            $display("FAIL reset_data got SWLEN=%h ERRCODE=%b ELAPSED=%h want 0",
                     sw.SWLEN, sw.ERRCODE, sw.ELAPSED);
        end
    endtask

    task automatic test_basic();
        bit to; res_t obs; res_t exp; int lowc; int gap;
        mode = 0; close_n = 10;
        exp_q.push_back(predict(0, 16'd10, 10));
        issue(16'd10);
        checks++;
        if (sw.BUSY !== 1'b1) begin
            errors++; $display("FAIL basic_busy_set got %b want 1", sw.BUSY);
        end
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL basic_result got %h (to=%0d) want %h", obs, to, exp);
        end
        checks++;
        if (lowc != INIT_PULSE) begin
            errors++; $display("FAIL basic_init_low got %0d cycles want %0d", lowc, INIT_PULSE);
        end
        checks++;
        if (sw.SWLEN !== 16'd10) begin
            errors++; $display("FAIL basic_swlen got %0d want 10", sw.SWLEN);
        end
        checks++;
        if (obs.elapsed < 6 || obs.elapsed > 14) begin
            errors++; $display("FAIL basic_elapsed_range got %0d want 6..14", obs.elapsed);
        end
        checks++;
        if (sw.BUSY !== 1'b0) begin
            errors++; $display("FAIL basic_busy_clr got %b want 0", sw.BUSY);
        end
        @(negedge clk);
        checks++;
        if (sw.ACK !== 1'b0) begin
            errors++; $display("FAIL basic_ack_pulse got %b want 0", sw.ACK);
        end
    endtask

    task automatic test_noopen();
        bit to; res_t obs; res_t exp; int lowc; int gap;
        mode = 1;
        exp_q.push_back(predict(1, 16'd12, 0));
        issue(16'd12);
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL noopen_result got %h (to=%0d) want %h", obs, to, exp);
        end
        checks++;
        if (gap != OPEN_TO) begin
            errors++; $display("FAIL noopen_latency got %0d want %0d", gap, OPEN_TO);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sw.ERRCODE !== 2'b01 || sw.ERR !== 1'b0) begin
            errors++; $display("FAIL noopen_hold got ERRCODE=%b ERR=%b want 01/0",
                               sw.ERRCODE, sw.ERR);
        end
    endtask

    task automatic test_early_timeout();
        bit to; res_t obs; res_t exp; int lowc; int gap;
        mode = 0; close_n = 5;
        exp_q.push_back(predict(0, 16'd20, 5));
        issue(16'd20);
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL early_result got %h (to=%0d) want %h", obs, to, exp);
        end
        @(negedge clk);
        mode = 2;
        exp_q.push_back(predict(2, 16'd20, 0));
        issue(16'd20);
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL timeout_result got %h (to=%0d) want %h", obs, to, exp);
        end
        @(negedge clk);
        mode = 1;
    endtask

    task automatic test_boundaries();
        bit to; res_t obs; res_t exp; int lowc; int gap;
        repeat (2) @(negedge clk);
        mode = 0; close_n = 0;
        exp_q.push_back(predict(0, 16'd0, 0));
        issue(16'd0);
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp || obs.elapsed > 1) begin
            errors++; $display("FAIL len0_result got %h (to=%0d) want %h", obs, to, exp);
        end
        @(negedge clk);
        mode = 2;
        exp_q.push_back(predict(2, 16'hFFFF, 0));
        issue(16'hFFFF);
        wait_done(70000, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL lenmax_result got %h (to=%0d) want %h", obs, to, exp);
        end
        @(negedge clk);
        mode = 1;
    endtask

    task automatic test_back_to_back();
        res_t obs; res_t exp; int start; int cyc; bit seen;
        repeat (2) @(negedge clk);
        mode = 0; close_n = 30;
        exp_q.push_back(predict(0, 16'd30, 30));
        start = done_pulses;
        sw.REQ = 1'b1;
        sw.LEN = 16'd30;
        @(negedge clk);
        cyc = 0; seen = 0; obs = '0;
        while (cyc < 200 && !seen) begin
            if (sw.ACK === 1'b1 || sw.ERR === 1'b1) begin
                obs = {sw.ACK, sw.ERR, sw.ERRCODE, sw.ELAPSED};
                sw.REQ = 1'b0;
                seen = 1;
            end else begin
                checks++;
                if (sw.SWLEN !== 16'd30) begin
                    errors++; $display("FAIL b2b_swlen_stable got %0d want 30", sw.SWLEN);
                end
                sw.LEN = 16'($urandom_range(0, 65535));
                sw.REQ = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        sw.REQ = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (!seen || obs !== exp) begin
            errors++; $display("FAIL b2b_result got %h (seen=%0d) want %h", obs, seen, exp);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_pulses - start != 1 || sw.BUSY !== 1'b0) begin
            errors++; $display("FAIL b2b_single_done got %0d pulses BUSY=%b want 1/0",
                               done_pulses - start, sw.BUSY);
        end
    endtask

    task automatic test_reset_mid();
        int falls;
        bit to; res_t obs; res_t exp; int lowc; int gap;
        for (int pass = 0; pass < 2; pass++) begin
            mode = 0; close_n = 40;
            issue(16'd40);
            if (pass == 0) repeat (8) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            checks++;
            if ({sw.INIT, sw.BUSY, sw.ACK, sw.ERR} !== 4'b1000) begin
                errors++; $display("FAIL rst_mid%0d got INIT/BUSY/ACK/ERR=%b want 1000",
                                   pass, {sw.INIT, sw.BUSY, sw.ACK, sw.ERR});
            end
            falls = init_falls;
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            repeat (5) @(negedge clk);
            checks++;
            if (init_falls != falls || sw.INIT !== 1'b1 || sw.BUSY !== 1'b0) begin
                errors++; $display("FAIL rst_release%0d got falls+%0d INIT=%b BUSY=%b want 0/1/0",
                                   pass, init_falls - falls, sw.INIT, sw.BUSY);
            end
        end
        close_n = 10;
        exp_q.push_back(predict(0, 16'd10, 10));
        issue(16'd10);
        wait_done(100, to, obs, lowc, gap);
        exp = exp_q.pop_front();
        checks++;
        if (to || obs !== exp) begin
            errors++; $display("FAIL post_reset_result got %h (to=%0d) want %h", obs, to, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        sw.REQ = 1'b0;
        sw.LEN = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        @(negedge clk);
        test_noopen();
        @(negedge clk);
        test_early_timeout();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
